// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN element-wise stages.
package cnn_pkg;

    localparam int ELEM_W = 32;

    typedef logic signed [ELEM_W-1:0] elem_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } relu_sched_state_e;

    // Width of an index able to address n items (never below 1 bit).
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping.
module rr_arbiter
    import cnn_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int PW      = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] winner
);

    // Scan from ptr upward, wrapping, and keep only the first hit.
    always_comb begin
        int          pos;
        logic        found;
        logic [PW-1:0] j;
        winner = '0;
        found  = 1'b0;
        pos    = 0;
        j      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = int'(ptr) + i;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            j = PW'(pos);
            if (!found && req[j]) begin
                winner[j] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/relu_scheduler.sv
// Time-shares one ReLU lane between NUM_REQ map producers, one whole map per grant.
module relu_scheduler
    import cnn_pkg::*;
#(
    parameter  int MAP_WIDTH = 8,
    parameter  int NUM_REQ   = 4,
    parameter  int DATA_W    = 32,
    localparam int N         = MAP_WIDTH * MAP_WIDTH,
    localparam int IW        = idx_w(N),
    localparam int PW        = idx_w(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     rd_en,
    output logic [IW-1:0]            rd_idx,
    input  logic signed [DATA_W-1:0] rd_data,
    output logic                     wr_en,
    output logic [IW-1:0]            wr_idx,
    output logic signed [DATA_W-1:0] wr_data,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy
);

    relu_sched_state_e state, state_nxt;

    logic [NUM_REQ-1:0] winner;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      grant_idx;
    logic [PW-1:0]      ptr_nxt;
    logic               any_req;
    logic               last_rd;
    logic               rd_pos;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req    (req),
        .ptr    (ptr),
        .winner (winner)
    );

    assign any_req = |req;
    assign last_rd = (state == RUN) && (rd_idx == IW'(N - 1));

    // Binary index of the held grant, used to advance the rr pointer past it.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i]) grant_idx = PW'(i);
    end

    assign ptr_nxt = (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: one map job is RUN (N reads), DRAIN (last write), DONE (pulse).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = RUN;
            RUN:     if (last_rd) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant, read walker, write pipeline and rr pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant  <= '0;
            rd_en  <= 1'b0;
            rd_idx <= '0;
            wr_en  <= 1'b0;
            wr_idx <= '0;
            ptr    <= '0;
        end else begin
            // Source data lands one cycle after the read, so the write trails by one.
            wr_en <= rd_en;
            if (rd_en) wr_idx <= rd_idx;
            case (state)
                IDLE: if (any_req) begin
                    grant  <= winner;
                    rd_en  <= 1'b1;
                    rd_idx <= '0;
                end
                RUN: begin
                    // Hold at N-1 on the last read rather than wrapping.
                    if (last_rd) rd_en  <= 1'b0;
                    else         rd_idx <= rd_idx + IW'(1);
                end
                DRAIN: ptr   <= ptr_nxt;
                DONE:  grant <= '0;
                default: ;
            endcase
        end
    end

    // ReLU on the arriving element; output forced to zero when not writing.
    assign rd_pos  = !rd_data[DATA_W-1] && (|rd_data);
    assign wr_data = (wr_en && rd_pos) ? rd_data : '0;

    assign done = (state == DONE) ? grant : '0;
    assign busy = (state != IDLE);

endmodule
